pipe_reg: RTL and testbench

- Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit registers with a valid/ready handshake on both ends.
- Synchronous active-high reset to a parametrised reset value, a synchronous flush, and an occupancy count.
- Sits between producer and consumer blocks to add configurable registered latency without losing throughput.
- Bubbles are collapsed under backpressure.

---
 rtl/pipe_reg_if.sv | 29 ++
 rtl/pipe_reg.sv | 73 +++++++
 tb/tb_pipe_reg.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_if.sv
// Handshake bundle for pipe_reg: producer side (in_*), consumer side (out_*),
// the synchronous flush request and the occupancy count.
interface pipe_reg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    // Environment side: drives requests, observes pipeline status.
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    // Pipeline side.
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_reg.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit registers with
// valid/ready on both ends, bubble collapse under backpressure, synchronous
// reset to RESET_VALUE, synchronous flush of valid bits and an occupancy count.
module pipe_reg #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic         clk,
    input logic         reset,
    pipe_reg_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             chain;
    logic [CW-1:0]    occ;

    // Stage acceptance: stage i may load when it, or any stage ahead of it,
    // is empty, or the consumer is taking the head. Accumulated from the
    // output end so no signal feeds back on itself.
    always_comb begin
        chain = bus.out_ready;
        adv   = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            chain = chain || !valid_q[DEPTH-1-j];
            adv[DEPTH-1-j] = chain;
        end
    end

    // Occupancy: number of stages currently holding a valid item.
    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ = occ + CW'(valid_q[i]);
        end
    end

    assign bus.in_ready  = adv[0] && !bus.flush;
    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.count     = occ;

    // Stage registers: reset beats flush beats normal advance; data only
    // moves with a valid item so empty stages keep their old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
        end else if (bus.flush) begin
            valid_q <= '0;
        end else begin
            if (adv[0]) begin
                valid_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    data_q[0] <= bus.in_data;
                end
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg. A (DEPTH=3, WIDTH=8) runs directed
// scenarios and random traffic against a queue-of-items reference model;
// a separate monitor checks output order against a scoreboard. B
// (DEPTH=1, WIDTH=1) gets a short directed single-stage sequence.
module tb_pipe_reg;
    localparam int         D  = 3;
    localparam logic [7:0] RV = 8'hA5;

    logic clk = 1'b0;
    logic reset;
    logic reset_b;

    int checks = 0;
    int errors = 0;

    // Reference model: per item its stage position and data, head first.
    int         pos [$];
    logic [7:0] md  [$];
    logic [7:0] m_last;
    // Scoreboard of items expected at the output, in order.
    logic [7:0] sb  [$];

    always #5 clk = ~clk;

    pipe_reg_if #(.WIDTH(8), .DEPTH(3)) a_if ();
    pipe_reg_if #(.WIDTH(1), .DEPTH(1)) b_if ();

    pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    pipe_reg #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (b_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Output monitor: every output transfer must match the oldest expected item.
    always @(negedge clk) begin
        if (reset === 1'b0 && a_if.out_valid === 1'b1 && a_if.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual=%0h required=none", a_if.out_data);
            end else begin
                check("out_order", 32'(a_if.out_data), 32'(sb.pop_front()));
            end
        end
    end

    // One clock of stimulus on A; call right after a rising edge.
    task automatic cycle_a(input logic rst, input logic fl, input logic iv,
                           input logic [7:0] id, input logic ordy);
        logic       m_ir, m_ov, in_x, out_x;
        logic [7:0] m_od;
        int         limit, np;
        #1;
        reset          = rst;
        a_if.flush     = fl;
        a_if.in_valid  = iv;
        a_if.in_data   = id;
        a_if.out_ready = ordy;
        @(negedge clk);
        m_ir = !fl && (pos.size() < D || ordy);
        m_ov = pos.size() > 0 && pos[0] == D - 1;
        m_od = m_ov ? md[0] : m_last;
        check("in_ready",  32'(a_if.in_ready),  32'(m_ir));
        check("out_valid", 32'(a_if.out_valid), 32'(m_ov));
        check("count",     32'(a_if.count),     32'(pos.size()));
        check("out_data",  32'(a_if.out_data),  32'(m_od));
        in_x  = iv && m_ir;
        out_x = m_ov && ordy;
        if (!rst && in_x) sb.push_back(id);
        @(posedge clk);
        if (rst) begin
            pos.delete(); md.delete(); sb.delete();
            m_last = RV;
        end else if (fl) begin
            pos.delete(); md.delete(); sb.delete();
        end else begin
            if (out_x) begin
                void'(pos.pop_front());
                void'(md.pop_front());
            end
            // Each item moves one stage forward unless the one ahead blocks it.
            limit = D;
            foreach (pos[k]) begin
                np = pos[k] + 1;
                if (np > limit - 1) np = limit - 1;
                pos[k] = np;
                limit  = np;
            end
            if (in_x) begin
                pos.push_back(0);
                md.push_back(id);
            end
            if (pos.size() > 0 && pos[0] == D - 1) m_last = md[0];
        end
    endtask

    initial begin
        reset          = 1'b1;
        a_if.flush     = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 8'h11;
        a_if.out_ready = 1'b0;
        reset_b        = 1'b1;
        b_if.flush     = 1'b0;
        b_if.in_valid  = 1'b0;
        b_if.in_data   = 1'b0;
        b_if.out_ready = 1'b0;
        m_last         = RV;

        // Reset held two edges with traffic offered.
        @(posedge clk);
        cycle_a(1, 0, 1, 8'h11, 0);
        cycle_a(0, 0, 0, 8'h00, 1);

        // Streaming 01..08 with out_ready held high, then drain.
        for (int v = 1; v <= 8; v++) cycle_a(0, 0, 1, 8'(v), 1);
        for (int k = 0; k < 4; k++) cycle_a(0, 0, 0, 8'h00, 1);

        // Bubble collapse under backpressure, then full with simultaneous transfer.
        cycle_a(0, 0, 1, 8'h10, 0);
        cycle_a(0, 0, 0, 8'h00, 0);
        cycle_a(0, 0, 1, 8'h20, 0);
        cycle_a(0, 0, 1, 8'h30, 0);
        cycle_a(0, 0, 1, 8'h99, 0);
        cycle_a(0, 0, 1, 8'h44, 1);
        for (int k = 0; k < 5; k++) cycle_a(0, 0, 0, 8'h00, 1);

        // Flush with two items held; 55 must never be accepted.
        cycle_a(0, 0, 1, 8'h61, 0);
        cycle_a(0, 0, 1, 8'h62, 0);
        cycle_a(0, 1, 1, 8'h55, 0);
        for (int k = 0; k < 3; k++) cycle_a(0, 0, 0, 8'h00, 1);

        // Flush while the head is being consumed.
        for (int k = 0; k < 3; k++) cycle_a(0, 0, 1, 8'h70 + 8'(k), 0);
        cycle_a(0, 1, 0, 8'h00, 1);
        cycle_a(0, 0, 0, 8'h00, 1);

        // Reset together with flush on a full, stalled pipeline.
        for (int k = 0; k < 3; k++) cycle_a(0, 0, 1, 8'h80 + 8'(k), 0);
        cycle_a(1, 1, 1, 8'h77, 0);
        cycle_a(0, 0, 0, 8'h00, 1);

        // Random traffic with alternating light and heavy backpressure.
        for (int i = 0; i < 1500; i++) begin
            logic       r_rst, r_fl, r_iv, r_or;
            logic [7:0] r_d;
            r_rst = ($urandom_range(0, 199) == 0);
            r_fl  = ($urandom_range(0, 59) == 0);
            r_iv  = ($urandom_range(0, 3) != 0);
            r_d   = 8'($urandom);
            r_or  = ((i / 250) % 2 == 0) ? ($urandom_range(0, 4) != 0)
                                         : ($urandom_range(0, 3) == 0);
            cycle_a(r_rst, r_fl, r_iv, r_d, r_or);
        end
        for (int k = 0; k < 5; k++) cycle_a(0, 0, 0, 8'h00, 1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Single-stage instance.
        #1;
        reset_b = 1'b0;
        b_if.in_valid = 1'b1; b_if.in_data = 1'b0; b_if.out_ready = 1'b0;
        @(negedge clk);
        check("b_rst_ready", 32'(b_if.in_ready),  32'd1);
        check("b_rst_valid", 32'(b_if.out_valid), 32'd0);
        check("b_rst_data",  32'(b_if.out_data),  32'd1);
        check("b_rst_count", 32'(b_if.count),     32'd0);
        @(posedge clk);
        #1;
        b_if.in_valid = 1'b1; b_if.in_data = 1'b1; b_if.out_ready = 1'b0;
        @(negedge clk);
        check("b_full_valid", 32'(b_if.out_valid), 32'd1);
        check("b_full_data",  32'(b_if.out_data),  32'd0);
        check("b_full_count", 32'(b_if.count),     32'd1);
        check("b_full_ready", 32'(b_if.in_ready),  32'd0);
        @(posedge clk);
        #1;
        b_if.out_ready = 1'b1;
        @(negedge clk);
        check("b_pass_ready", 32'(b_if.in_ready),  32'd1);
        check("b_pass_data",  32'(b_if.out_data),  32'd0);
        @(posedge clk);
        #1;
        b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
        @(negedge clk);
        check("b_next_valid", 32'(b_if.out_valid), 32'd1);
        check("b_next_data",  32'(b_if.out_data),  32'd1);
        @(posedge clk);
        #1;
        b_if.in_valid = 1'b1; b_if.in_data = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_b = 1'b1; b_if.flush = 1'b1;
        @(posedge clk);
        #1;
        reset_b = 1'b0; b_if.flush = 1'b0; b_if.in_valid = 1'b0;
        @(negedge clk);
        check("b_rst2_valid", 32'(b_if.out_valid), 32'd0);
        check("b_rst2_data",  32'(b_if.out_data),  32'd1);
        check("b_rst2_count", 32'(b_if.count),     32'd0);
        check("b_rst2_ready", 32'(b_if.in_ready),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
